// File: rtl/spd_ctrl.sv
// spd_ctrl: sequencer for the survivor path decoder (spd) of the Viterbi decoder.
// Admits ACS decision beats, clears and fills the survivor chain, and pairs each
// post-fill shift with one decoded output bit. It appends DEPTH zero-decision tail
// shifts per frame, so an N-decision frame yields exactly N output bits.
// Optional feature macro: SPD_CTRL_ERR_EN adds the sticky seq_err protocol flag.
module spd_ctrl #(
   parameter int DEPTH = 15,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic dec_valid,
   output logic dec_ready,
   input  logic frame_start,
   input  logic frame_last,
   output logic spd_en,
   output logic spd_clr,
   output logic flush_sel,
   input  logic spd_in,
   output logic out_bit,
   output logic out_valid,
   input  logic out_ready,
   output logic out_last,
   output logic busy
`ifdef SPD_CTRL_ERR_EN
   ,
   output logic seq_err
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_RUN,
      S_FLUSH
   } state_t;

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);
   localparam logic [CW-1:0] ONE_C    = CW'(1);

   state_t        state, state_nxt;
   logic [CW-1:0] fill_cnt, fill_nxt;
   logic [CW-1:0] flush_cnt, flush_nxt;
   logic          filled;
   logic          start_req;

   // The chain holds DEPTH decisions once fill_cnt saturates; every shift from
   // then on pushes one decoded bit out of the far end.
   assign filled = (fill_cnt == DEPTH_C);

   // Qualified by reset so the chain is held cleared and never advances while
   // reset is asserted, even if a frame start is presented.
   assign start_req = reset & dec_valid & frame_start;

   assign busy    = (state != S_IDLE);
   assign out_bit = spd_in;

   // Next-state, counter update and handshake/control decode.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves
      // a signal unassigned and no latch is inferred.
      state_nxt = state;
      fill_nxt  = fill_cnt;
      flush_nxt = flush_cnt;
      dec_ready = 1'b0;
      spd_en    = 1'b0;
      spd_clr   = 1'b0;
      flush_sel = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;

      case (state)
         S_IDLE: begin
            // Beats without frame_start are accepted and dropped.
            dec_ready = 1'b1;
            spd_clr   = ~start_req;
            if (start_req) begin
               spd_en    = 1'b1;
               fill_nxt  = ONE_C;
               flush_nxt = '0;
               state_nxt = frame_last ? S_FLUSH : S_FILL;
            end
         end

         S_FILL: begin
            dec_ready = 1'b1;
            spd_en    = dec_valid;
            if (dec_valid) begin
               fill_nxt = fill_cnt + ONE_C;
               if (frame_last)
                  state_nxt = S_FLUSH;
               else if (fill_cnt == DEPTH_M1)
                  state_nxt = S_RUN;
            end
         end

         S_RUN: begin
            // Input and output handshake as one: a decision enters only when
            // the bit it pushes out is taken, so nothing is duplicated or lost.
            out_valid = dec_valid;
            dec_ready = out_ready;
            spd_en    = dec_valid & out_ready;
            if (dec_valid && out_ready && frame_last)
               state_nxt = S_FLUSH;
         end

         S_FLUSH: begin
            // Short frames still need fill shifts before the chain emits; those
            // free-run, while emitting shifts wait for the consumer.
            flush_sel = 1'b1;
            out_valid = filled;
            spd_en    = filled ? out_ready : 1'b1;
            out_last  = filled && (flush_cnt == DEPTH_M1);
            if (spd_en) begin
               if (flush_cnt == DEPTH_M1) begin
                  state_nxt = S_IDLE;
                  fill_nxt  = '0;
                  flush_nxt = '0;
               end else begin
                  flush_nxt = flush_cnt + ONE_C;
                  if (!filled)
                     fill_nxt = fill_cnt + ONE_C;
               end
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of evaluation order.
      if (!reset) begin
         state     <= S_IDLE;
         fill_cnt  <= '0;
         flush_cnt <= '0;
      end else begin
         state     <= state_nxt;
         fill_cnt  <= fill_nxt;
         flush_cnt <= flush_nxt;
      end
   end

`ifdef SPD_CTRL_ERR_EN
   logic err_evt;

   // Protocol violations: frame_start on an accepted beat inside a frame, or
   // frame_last on an accepted beat that does not open a frame.
   assign err_evt = dec_valid & dec_ready &
                    (( frame_start & (state != S_IDLE)) |
                     ( frame_last & ~frame_start & (state == S_IDLE)));

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         seq_err <= 1'b0;
      else if (err_evt)
         seq_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_spd_ctrl.sv
// tb_spd_ctrl: self-checking bench for spd_ctrl. A stand-in survivor chain
// (plain DEPTH-deep delay line) feeds spd_in so that decoded bit j is the data
// bit of decision j. A frame-level model (decision counts, tail count, queue of
// expected bits) predicts all outputs; one compare process checks every cycle.
// Build with SPD_CTRL_ERR_EN defined to also cover seq_err.
module tb_spd_ctrl;
   localparam int DEPTH = 15;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic dec_valid = 1'b0;
   logic frame_start = 1'b0;
   logic frame_last = 1'b0;
   logic out_ready = 1'b1;
   logic dbit = 1'b0;
   logic dec_ready, spd_en, spd_clr, flush_sel, spd_in;
   logic out_bit, out_valid, out_last, busy;
`ifdef SPD_CTRL_ERR_EN
   logic seq_err;
`endif

   spd_ctrl #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .dec_valid  (dec_valid),
      .dec_ready  (dec_ready),
      .frame_start(frame_start),
      .frame_last (frame_last),
      .spd_en     (spd_en),
      .spd_clr    (spd_clr),
      .flush_sel  (flush_sel),
      .spd_in     (spd_in),
      .out_bit    (out_bit),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy)
`ifdef SPD_CTRL_ERR_EN
      ,
      .seq_err    (seq_err)
`endif
   );

   always #5 clk = ~clk;

   // Stand-in survivor chain: the decision entering now leaves DEPTH shifts later.
   logic [DEPTH-1:0] sr;
   assign spd_in = sr[DEPTH-1];
   always @(posedge clk) begin
      if (spd_clr)
         sr <= '0;
      else if (spd_en)
         sr <= {sr[DEPTH-2:0], (flush_sel ? 1'b0 : dbit)};
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level reference model.
   bit m_in_frame = 0;
   bit m_last = 0;
   bit m_err = 0;
   int m_nacc = 0;
   int m_tail = 0;
   bit exp_q[$];

   // Per-frame statistics observed on the DUT, for hand-computed checks.
   int frame_cyc = 0, first_valid = -1, hs_cnt = 0, last_hs = 0;
   int idle_at = -1, hs_flush = 0, nvalid = 0, fsel_cyc = 0;

   logic e_ready, e_en, e_clr, e_fsel, e_ov, e_ol, acc, popped;

   // Compare process: predicts outputs from frame counts and checks each cycle.
   always @(negedge clk) begin
      if (!reset) begin
         check("rst_dec_ready", dec_ready, 1);
         check("rst_spd_clr", spd_clr, 1);
         check("rst_spd_en", spd_en, 0);
         check("rst_flush_sel", flush_sel, 0);
         check("rst_out_valid", out_valid, 0);
         check("rst_out_last", out_last, 0);
         check("rst_busy", busy, 0);
`ifdef SPD_CTRL_ERR_EN
         check("rst_seq_err", seq_err, 0);
`endif
         m_in_frame = 0; m_last = 0; m_err = 0; m_nacc = 0; m_tail = 0;
         exp_q.delete();
      end else begin
         if (!m_in_frame && dec_valid && frame_start) begin
            frame_cyc = 0; first_valid = -1; hs_cnt = 0; last_hs = 0;
            idle_at = -1; hs_flush = 0; nvalid = 0; fsel_cyc = 0;
         end else begin
            frame_cyc++;
         end

         e_ready = 1'b0; e_en = 1'b0; e_clr = 1'b0; e_fsel = 1'b0; e_ov = 1'b0; e_ol = 1'b0;
         if (!m_in_frame) begin
            e_ready = 1'b1;
            e_en    = dec_valid & frame_start;
            e_clr   = ~(dec_valid & frame_start);
         end else if (!m_last) begin
            if (m_nacc < DEPTH) begin
               e_ready = 1'b1;
               e_en    = dec_valid;
            end else begin
               e_ov    = dec_valid;
               e_ready = out_ready;
               e_en    = dec_valid & out_ready;
            end
         end else begin
            e_fsel = 1'b1;
            e_ov   = (m_nacc + m_tail >= DEPTH);
            e_en   = e_ov ? out_ready : 1'b1;
            e_ol   = e_ov && (m_tail == DEPTH - 1);
         end

         check("dec_ready", dec_ready, e_ready);
         check("spd_en", spd_en, e_en);
         check("spd_clr", spd_clr, e_clr);
         check("flush_sel", flush_sel, e_fsel);
         check("out_valid", out_valid, e_ov);
         check("out_last", out_last, e_ol);
         check("busy", busy, m_in_frame);
         check("out_bit_follow", out_bit, spd_in);
`ifdef SPD_CTRL_ERR_EN
         check("seq_err", seq_err, m_err);
`endif

         if (out_valid && first_valid < 0) first_valid = frame_cyc;
         if (out_valid && out_ready) begin
            hs_cnt++;
            if (flush_sel) hs_flush++;
            if (out_last) last_hs = hs_cnt;
         end
         nvalid   += int'(out_valid);
         fsel_cyc += int'(flush_sel);
         if (!busy && frame_cyc > 0 && idle_at < 0) idle_at = frame_cyc;

         if (e_ov && out_ready) begin
            check("bit_available", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               popped = exp_q.pop_front();
               check("out_bit_data", out_bit, popped);
            end
         end

         acc = dec_valid & e_ready;
         if (!m_in_frame) begin
            if (acc && frame_start) begin
               m_in_frame = 1; m_last = frame_last; m_nacc = 1; m_tail = 0;
               exp_q.delete();
               exp_q.push_back(dbit);
            end else if (acc && frame_last) begin
               m_err = 1;
            end
         end else if (!m_last) begin
            if (acc) begin
               m_nacc++;
               exp_q.push_back(dbit);
               if (frame_start) m_err = 1;
               if (frame_last) m_last = 1;
            end
         end else if (e_en) begin
            m_tail++;
            if (m_tail == DEPTH) begin
               check("bits_left_at_frame_end", exp_q.size(), 0);
               m_in_frame = 0; m_last = 0; m_nacc = 0; m_tail = 0;
            end
         end
      end
   end

   // 0: out_ready held high, 1: toggles 1010..., 2: random (mostly high).
   int rmode = 0;

   task automatic step();
      @(posedge clk);
      #1;
      case (rmode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   endtask

   // Offers n beats (gap = percent chance of an idle cycle); beat inj also
   // carries frame_start. Returns just after the posedge accepting the last beat.
   task automatic send_frame(input int n, input int gap, input int inj);
      int  i = 0;
      int  guard = 0;
      bit  taken;
      dbit = 1'($urandom);
      while (i < n && guard < 2000) begin
         dec_valid   = (int'($urandom_range(0, 99)) >= gap);
         frame_start = (i == 0) || (i == inj);
         frame_last  = (i == n - 1);
         @(negedge clk);
         taken = dec_valid & dec_ready;
         step();
         if (taken) begin
            i++;
            dbit = 1'($urandom);
         end
         guard++;
      end
      dec_valid = 1'b0; frame_start = 1'b0; frame_last = 1'b0;
      if (i < n) check("frame_accept_timeout", i, n);
   endtask

   task automatic wait_idle();
      int g = 0;
      @(negedge clk);
      while (busy && g < 300) begin
         step();
         @(negedge clk);
         g++;
      end
      check("idle_timeout", busy, 0);
      step();
   endtask

   initial begin
      int n;
      #2 reset = 1'b0;
      @(negedge clk);
      check("hold_rst_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("idle_spd_clr", spd_clr, 1);
      check("idle_dec_ready", dec_ready, 1);
      check("idle_busy", busy, 0);
      check("idle_out_valid", out_valid, 0);
      check("idle_spd_en", spd_en, 0);
      step();

      // 20-beat frame, consumer always ready.
      rmode = 0;
      send_frame(20, 0, -1);
      wait_idle();
      check("f20_first_valid_cycle", first_valid, 15);
      check("f20_bits", hs_cnt, 20);
      check("f20_last_index", last_hs, 20);
      check("f20_bits_in_flush", hs_flush, 15);
      check("f20_idle_cycle", idle_at, 35);

      // Single-beat frame.
      send_frame(1, 0, -1);
      wait_idle();
      check("f1_flush_cycles", fsel_cyc, 15);
      check("f1_valid_cycles", nvalid, 1);
      check("f1_bits", hs_cnt, 1);
      check("f1_last_index", last_hs, 1);
      check("f1_idle_cycle", idle_at, 16);

      // 20-beat frame, consumer toggling.
      rmode = 1;
      send_frame(20, 0, -1);
      wait_idle();
      check("f20t_bits", hs_cnt, 20);
      check("f20t_last_index", last_hs, 20);

      // Reset during the tail after seven flush shifts.
      rmode = 0;
      send_frame(20, 0, -1);
      repeat (7) step();
      reset = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_out_last", out_last, 0);
      check("midrst_dec_ready", dec_ready, 1);
      step();
      step();
      reset = 1'b1;
      check("midrst_bits_before", hs_cnt, 12);
      check("midrst_no_last", last_hs, 0);
      send_frame(10, 0, -1);
      wait_idle();
      check("after_rst_bits", hs_cnt, 10);
      check("after_rst_last_index", last_hs, 10);

      // frame_start on a beat inside RUN is ordinary data.
      send_frame(20, 0, 17);
      wait_idle();
      check("inj_bits", hs_cnt, 20);
      check("inj_last_index", last_hs, 20);
`ifdef SPD_CTRL_ERR_EN
      check("inj_seq_err_sticky", seq_err, 1);
`endif

      // Randomized frames, gaps and back-pressure; occasional stray beats in IDLE.
      rmode = 2;
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 5))
            0:       n = 1;
            1:       n = DEPTH - 1;
            2:       n = DEPTH;
            3:       n = DEPTH + 1;
            default: n = int'($urandom_range(1, 40));
         endcase
         send_frame(n, int'($urandom_range(0, 40)), -1);
         if ($urandom_range(0, 3) == 0) begin
            wait_idle();
            dec_valid   = 1'b1;
            frame_start = 1'b0;
            frame_last  = 1'($urandom);
            @(negedge clk);
            step();
            dec_valid  = 1'b0;
            frame_last = 1'b0;
         end
      end
      wait_idle();
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
